// File: rtl/fetch_stage.sv
// Instruction fetch/decode front end: two byte reads per instruction, stage registers with valid/complete handshake.
// Optional interrupt redirect when the INTERRUPT_EN macro is defined.
module fetch_stage #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [4:0] HALT_OPCODE = 5'h1F
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] ImemAddr,
    output logic       ImemRdEn,
    input  logic [7:0] ImemData,
    output logic [4:0] StageRegInstr_out,
    output logic [2:0] StageRegAddrMode_out,
    output logic [7:0] StageRegData_out,
    output logic [7:0] StageRegPCtr_out,
    output logic       StageValid,
    input  logic       StageComplete,
    input  logic [7:0] NextPctr,
    input  logic       IntReq,
    input  logic [7:0] InteruptAdrReg,
    output logic       IntAck,
    output logic [7:0] SavedPctr,
    output logic       Halted
);

    typedef enum logic [2:0] {
        FETCH_HI = 3'd0,
        FETCH_LO = 3'd1,
        LATCH    = 3'd2,
        PRESENT  = 3'd3,
        HALTED   = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pc;
    logic [7:0] byte0;
    logic       done;
    logic       is_halt;
    logic       int_present;
    logic       int_halted;

    // StageValid is high exactly in PRESENT, so completion is only honoured there.
    assign done    = (state == PRESENT) && StageComplete;
    assign is_halt = (StageRegInstr_out == HALT_OPCODE);

`ifdef INTERRUPT_EN
    assign int_present = done && IntReq;
    assign int_halted  = (state == HALTED) && IntReq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IntAck    <= 1'b0;
            SavedPctr <= 8'h00;
        end else begin
            IntAck <= int_present || int_halted;
            if (int_present) begin
                SavedPctr <= NextPctr;
            end else if (int_halted) begin
                SavedPctr <= pc;
            end
        end
    end
`else
    logic unused_int;
    assign unused_int  = ^{IntReq, InteruptAdrReg};
    assign int_present = 1'b0;
    assign int_halted  = 1'b0;
    assign IntAck      = 1'b0;
    assign SavedPctr   = 8'h00;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH_HI;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_HI: state_nxt = FETCH_LO;
            FETCH_LO: state_nxt = LATCH;
            LATCH:    state_nxt = PRESENT;
            PRESENT: begin
                if (done) begin
                    // An interrupt wins over the halt redirect.
                    if (int_present) begin
                        state_nxt = FETCH_HI;
                    end else if (is_halt) begin
                        state_nxt = HALTED;
                    end else begin
                        state_nxt = FETCH_HI;
                    end
                end
            end
            HALTED: begin
                if (int_halted) begin
                    state_nxt = FETCH_HI;
                end
            end
            default: state_nxt = FETCH_HI;
        endcase
    end

    always_comb begin
        ImemAddr = pc;
        ImemRdEn = 1'b0;
        case (state)
            FETCH_HI: begin
                ImemAddr = pc;
                ImemRdEn = 1'b1;
            end
            FETCH_LO: begin
                ImemAddr = pc + 8'd1;
                ImemRdEn = 1'b1;
            end
            default: begin
                ImemAddr = pc;
                ImemRdEn = 1'b0;
            end
        endcase
        if (reset) begin
            ImemRdEn = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc                   <= RESET_PC;
            byte0                <= 8'h00;
            StageRegInstr_out    <= 5'h00;
            StageRegAddrMode_out <= 3'h0;
            StageRegData_out     <= 8'h00;
            StageRegPCtr_out     <= 8'h00;
            StageValid           <= 1'b0;
            Halted               <= 1'b0;
        end else begin
            case (state)
                FETCH_LO: begin
                    byte0 <= ImemData;
                end
                LATCH: begin
                    StageRegInstr_out    <= byte0[7:3];
                    StageRegAddrMode_out <= byte0[2:0];
                    StageRegData_out     <= ImemData;
                    StageRegPCtr_out     <= pc;
                    StageValid           <= 1'b1;
                end
                PRESENT: begin
                    if (done) begin
                        StageValid <= 1'b0;
                        pc         <= int_present ? InteruptAdrReg : NextPctr;
                        Halted     <= !int_present && is_halt;
                    end
                end
                HALTED: begin
                    if (int_halted) begin
                        pc     <= InteruptAdrReg;
                        Halted <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
